div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a division.
REQ-005 SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend  input  XLEN  rs1 value, sampled only when start is accepted.
REQ-007 SHALL have port divisor  input  XLEN  rs2 value, sampled only when start is accepted.
REQ-008 SHALL have port abort  input  1  pipeline flush; kills any operation in flight.
REQ-009 SHALL have port result  output  XLEN  quotient or remainder per latched op.
REQ-010 SHALL have port busy  output  1  iteration in progress; drives hazard-unit mul_div_busy.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid this cycle.

Function
REQ-012 SHALL implement states IDLE, COMPUTE, DONE.
REQ-013 start SHALL be accepted in IDLE or DONE and SHALL be ignored in COMPUTE.
REQ-014 On acceptance, op, operand magnitudes and the sign flags SHALL be latched; the input ports SHALL NOT be read again for that operation.
REQ-015 Signed ops (DIV, REM) SHALL divide absolute values; the quotient SHALL be negated when operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-016 Normal path: accepted start -> COMPUTE with iteration counter = XLEN; one restoring shift-subtract step per cycle; counter decrements each cycle; when counter reaches 1 the next state SHALL be DONE.
REQ-017 Latency: done SHALL assert exactly XLEN+1 cycles after the cycle in which start was sampled (33 for XLEN=32); busy SHALL be high for exactly the XLEN cycles in between.
REQ-018 Divisor zero: next state SHALL be DONE directly (done one cycle after start, busy never high); quotient all ones, remainder = dividend (unsigned and signed).
REQ-019 Signed overflow (DIV/REM, dividend = 1 followed by XLEN-1 zeros, divisor = all ones): next state SHALL be DONE directly; quotient = dividend, remainder = 0.
REQ-020 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE unless a new start is accepted in that cycle.
REQ-021 A start accepted in DONE SHALL enter COMPUTE (or DONE for a special case) the next cycle with no idle gap.
REQ-022 result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during COMPUTE.
REQ-023 abort in any state SHALL force IDLE on the next edge; done SHALL NOT assert for the killed operation; result SHALL keep its prior value.
REQ-024 abort and start in the same cycle: abort SHALL win; start SHALL be dropped.
REQ-025 Arithmetic: partial remainder SHALL be XLEN+1 bits wide to hold the subtract borrow; no other widening SHALL be used.

Reset
REQ-026 reset high at an edge SHALL force IDLE, busy=0, done=0, result=0, iteration counter=0, with priority over start and abort.
REQ-027 reset asserted mid-COMPUTE SHALL discard the operation; no done SHALL follow.

Verification
REQ-028 DIVU 100/7, start at cycle 0 -> busy cycles 1..32, done at cycle 33, result 14; REMU same operands -> result 2.
REQ-029 DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> result 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
REQ-030 DIVU 5/0 -> done at cycle 1, busy never high, result 0xFFFFFFFF; REM 0x80000005/0 -> result 0x80000005.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> done at cycle 1, result 0x80000000; REM same -> result 0.
REQ-032 Start DIVU 9/3, abort at cycle 10 -> busy low from cycle 11, no done; start at cycle 10 with abort also dropped; a later start 8/2 -> result 4 after 33 cycles.
REQ-033 Back-to-back: second start (DIVU 50/5) in the DONE cycle of the first -> second done exactly 33 cycles later, result 10; start pulses during COMPUTE ignored with no effect on result.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish early.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic            r_busy;
  logic            r_done;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;
  logic [XLEN:0]   w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [XLEN-1:0] w_fin;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & dividend[XLEN-1];
  assign w_b_neg  = w_signed & divisor[XLEN-1];
  assign w_a_abs  = w_a_neg ? -dividend : dividend;
  assign w_b_abs  = w_b_neg ? -divisor : divisor;
  assign w_zero   = (divisor == '0);
  assign w_ovf    = w_signed
                  & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  & (&divisor);

  // Zero divisor takes priority; it also covers the signed cases.
  assign w_special = w_zero
                   ? (op[1] ? dividend : '1)
                   : (op[1] ? '0 : dividend);

  assign w_rem_sh = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_qbit   = ~w_diff[XLEN];
  assign w_rem_nx = w_qbit ? w_diff : w_rem_sh;
  assign w_quo_nx = {r_quo[XLEN-2:0], w_qbit};

  assign w_q_fin = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_r_fin = r_neg_r ? -w_rem_nx[XLEN-1:0]
                           : w_rem_nx[XLEN-1:0];
  assign w_fin   = r_is_rem ? w_r_fin : w_q_fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        COMPUTE: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_fin;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            r_is_rem <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_zero || w_ovf) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= w_special;
            end else begin
              r_state <= COMPUTE;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(XLEN);
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_div   <= w_b_abs;
            end
          end
        end
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic, latency, early-out cases,
// abort, reset and back-to-back issue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        abort;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .abort    (abort),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, then count cycles until done.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int elat);
    int lat;
    int bc;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    op = ~o; dividend = $urandom; divisor = $urandom;
    lat = 1;
    bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " lat"}, lat, elat);
    chk({tag, " busy"}, bc, elat - 1);
    chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    chk({tag, " res"}, result, er);
    @(negedge clk);
    chk({tag, " pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " hold"}, result, er);
  endtask

  initial begin
    int lat;
    int cnt_d;
    int cnt_b;
    int drift;
    reset = 1'b1; start = 1'b0; op = DIVU;
    dividend = '0; divisor = '0; abort = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst res", result, 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    do_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 33);
    do_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    do_op("rem -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    do_op("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    do_op("rem 7/-2", REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    do_op("div -8/-2", DIV, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd4, 33);
    do_op("divu max/1", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    do_op("remu max/16", REMU, 32'hFFFFFFFF, 32'd16, 32'hF, 33);
    do_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    do_op("rem x/0", REM, 32'h80000005, 32'd0, 32'h80000005, 1);
    do_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1);
    do_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    do_op("divu 100/7 b", DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Abort at cycle 10 with a simultaneous start.
    @(negedge clk);
    start = 1'b1; op = DIVU; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort busy c10", {31'd0, busy}, 32'd1);
    abort = 1'b1; start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort busy c11", {31'd0, busy}, 32'd0);
    chk("abort done c11", {31'd0, done}, 32'd0);
    cnt_d = 0;
    cnt_b = 0;
    repeat (40) begin
      if (done) cnt_d++;
      if (busy) cnt_b++;
      @(negedge clk);
    end
    chk("abort no done", cnt_d, 0);
    chk("abort dropped start", cnt_b, 0);
    chk("abort res kept", result, 32'd14);
    do_op("divu 8/2", DIVU, 32'd8, 32'd2, 32'd4, 33);

    // Back-to-back issue from the DONE cycle, with ignored pulses.
    @(negedge clk);
    start = 1'b1; op = DIVU; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b first lat", lat, 33);
    chk("b2b first res", result, 32'd14);
    start = 1'b1; op = DIVU; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0; dividend = 32'd1000; divisor = 32'd1;
    lat = 1;
    drift = 0;
    cnt_b = 0;
    while (!done && lat < 40) begin
      if (busy) cnt_b++;
      if (result !== 32'd14) drift++;
      start = (lat == 5 || lat == 20);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("b2b second lat", lat, 33);
    chk("b2b busy", cnt_b, 32);
    chk("b2b no drift", drift, 0);
    chk("b2b second res", result, 32'd10);
    @(negedge clk);
    chk("b2b ignored start", {31'd0, busy}, 32'd0);

    // Reset in the middle of an operation.
    start = 1'b1; op = DIVU; dividend = 32'd77; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst res", result, 32'd0);
    cnt_d = 0;
    repeat (40) begin
      if (done) cnt_d++;
      @(negedge clk);
    end
    chk("mid rst no done", cnt_d, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
